// File: rtl/qos_wrr_arbiter_pkg.sv
// Shared definitions for the QoS weighted round-robin arbiter.
//   state_e : scheduler FSM states (idle / serving VC0 / serving VC1)
//   VC0/VC1 : selector encodings for the two virtual channels
package qos_wrr_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StServe0 = 2'd1,
        StServe1 = 2'd2
    } state_e;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    // FSM state that owns the turn of a given VC.
    function automatic state_e serve_state(input logic vc);
        return (vc == VC1) ? StServe1 : StServe0;
    endfunction

endpackage

// File: rtl/qos_credit_counter.sv
// Saturating per-turn grant counter for the WRR arbiter.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_one_i     : start a new turn (cnt = 1)
//   incr_i         : one more grant in the current turn (saturates at all-ones)
//   clear_i        : end of activity (cnt = 0)
//   weight_i       : live quota of the VC being served; 0 behaves as 1
//   exhausted_o    : cnt >= effective weight
module qos_credit_counter #(
    parameter int unsigned WeightW = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_one_i,
    input  logic               incr_i,
    input  logic               clear_i,
    input  logic [WeightW-1:0] weight_i,
    output logic               exhausted_o
);

    logic [WeightW-1:0] cnt_q, cnt_d;
    logic [WeightW-1:0] eff_weight;

    always_comb begin
        eff_weight = (weight_i == '0) ? WeightW'(1) : weight_i;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_one_i) begin
            cnt_d = WeightW'(1);
        end else if (incr_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WeightW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A weight lowered mid-turn below cnt also reads as exhausted.
    assign exhausted_o = (cnt_q >= eff_weight);

endmodule

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin scheduler between two VC FIFOs sharing one datapath.
//   clk, reset_L          : clock, asynchronous active-low reset
//   ENB                   : global enable (0 freezes the scheduler)
//   vc0_empty/vc1_empty   : FIFO empty flags; a non-empty VC is eligible
//   vc0_data/vc1_data     : FIFO heads, consumed in the cycle of the pop
//   down_almost_full      : downstream backpressure, stalls like ENB=0
//   weight0/weight1       : per-turn quotas, 0 treated as 1, sampled live
//   vc0_pop/vc1_pop       : combinational pop strobes, mutually exclusive
//   data_out/valid_out/selector : registered popped word, valid, source VC
module qos_wrr_arbiter
    import qos_wrr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned WEIGHT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  ENB,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  down_almost_full,
    input  logic [WEIGHT_W-1:0]   weight0,
    input  logic [WEIGHT_W-1:0]   weight1,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  selector
);

    state_e state_q, state_d;

    logic stall;
    logic elig0, elig1;
    logic cur_vc, cur_elig, oth_elig;
    logic grant_vld, grant_vc;
    logic cnt_load, cnt_incr, cnt_clear;
    logic exhausted;
    logic [WEIGHT_W-1:0] cur_weight;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  sel_q;

    assign stall  = !ENB || down_almost_full;
    assign elig0  = !vc0_empty;
    assign elig1  = !vc1_empty;

    assign cur_vc     = (state_q == StServe1) ? VC1 : VC0;
    assign cur_elig   = (cur_vc == VC1) ? elig1 : elig0;
    assign oth_elig   = (cur_vc == VC1) ? elig0 : elig1;
    assign cur_weight = (cur_vc == VC1) ? weight1 : weight0;

    qos_credit_counter #(
        .WeightW (WEIGHT_W)
    ) u_credit (
        .clk_i       (clk),
        .rst_ni      (reset_L),
        .load_one_i  (cnt_load),
        .incr_i      (cnt_incr),
        .clear_i     (cnt_clear),
        .weight_i    (cur_weight),
        .exhausted_o (exhausted)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant decision and counter controls. A stall leaves all at hold.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_vc  = VC0;
        cnt_load  = 1'b0;
        cnt_incr  = 1'b0;
        cnt_clear = 1'b0;
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (elig0) begin
                        grant_vld = 1'b1;
                        grant_vc  = VC0;
                        cnt_load  = 1'b1;
                        state_d   = StServe0;
                    end else if (elig1) begin
                        grant_vld = 1'b1;
                        grant_vc  = VC1;
                        cnt_load  = 1'b1;
                        state_d   = StServe1;
                    end
                end
                StServe0, StServe1: begin
                    if (cur_elig && !exhausted) begin
                        grant_vld = 1'b1;
                        grant_vc  = cur_vc;
                        cnt_incr  = 1'b1;
                    end else if (oth_elig) begin
                        grant_vld = 1'b1;
                        grant_vc  = ~cur_vc;
                        cnt_load  = 1'b1;
                        state_d   = serve_state(~cur_vc);
                    end else if (cur_elig) begin
                        // Quota spent but nobody else waiting: refresh without a bubble.
                        grant_vld = 1'b1;
                        grant_vc  = cur_vc;
                        cnt_load  = 1'b1;
                    end else begin
                        cnt_clear = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                    state_d   = StIdle;
                end
            endcase
        end
    end

    // Pop strobes; reset gating drops them immediately on an async reset.
    always_comb begin
        vc0_pop = reset_L && grant_vld && (grant_vc == VC0);
        vc1_pop = reset_L && grant_vld && (grant_vc == VC1);
    end

    // Output register: capture the popped word, otherwise hold data/selector.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= VC0;
        end else if (grant_vld) begin
            data_q  <= (grant_vc == VC1) ? vc1_data : vc0_data;
            valid_q <= 1'b1;
            sel_q   <= grant_vc;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign selector  = sel_q;

endmodule
